// File: rtl/draw_rect_ctl.sv
// Frame-synchronous rectangle config controller: arbitrates two update requesters into a
// shadow register and commits it at vblank start. Optional drop counter: DRAW_RECT_CTL_STATS_EN.
module draw_rect_ctl #(
    parameter int unsigned H_ACTIVE = 800,
    parameter int unsigned V_ACTIVE = 600,
    parameter int unsigned RECT_W   = 30,
    parameter int unsigned RECT_H   = 350,
    parameter int unsigned INIT_X   = 60,
    parameter int unsigned INIT_Y   = 150,
    parameter logic [11:0] INIT_RGB = 12'hdf3
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic        vblnk_in,
    input  logic [1:0]  req_valid,
    input  logic [21:0] req_x,
    input  logic [21:0] req_y,
    input  logic [23:0] req_rgb,
    output logic [1:0]  req_ready,
    output logic [10:0] rect_x,
    output logic [10:0] rect_y,
    output logic [11:0] rect_rgb,
    output logic        rect_en,
    output logic        commit_pulse,
`ifdef DRAW_RECT_CTL_STATS_EN
    output logic [7:0]  drop_cnt,
`endif
    output logic [15:0] frame_cnt
);

    localparam int unsigned CW = 11;
    localparam int unsigned RW = 12;
    localparam logic [CW-1:0] X_MAX = CW'(H_ACTIVE - RECT_W);
    localparam logic [CW-1:0] Y_MAX = CW'(V_ACTIVE - RECT_H);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_PENDING = 2'd1;
    localparam logic [1:0] S_COMMIT  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          vblnk_d_q;
    logic          last_grant_q, last_grant_d;
    logic [CW-1:0] shadow_x_q, shadow_x_d, shadow_y_q, shadow_y_d;
    logic [RW-1:0] shadow_rgb_q, shadow_rgb_d;
    logic [CW-1:0] rect_x_q, rect_x_d, rect_y_q, rect_y_d;
    logic [RW-1:0] rect_rgb_q, rect_rgb_d;
    logic          rect_en_q, rect_en_d;
    logic          commit_q, commit_d;
    logic [15:0]   frame_q, frame_d;
`ifdef DRAW_RECT_CTL_STATS_EN
    logic [7:0]    drop_q, drop_d;
`endif

    logic          vblnk_rise_c;
    logic [1:0]    grant_c;
    logic          xfer_c;
    logic          sel_c;
    logic [CW-1:0] sel_x_c, sel_y_c;
    logic [RW-1:0] sel_rgb_c;

    assign vblnk_rise_c = vblnk_in & ~vblnk_d_q;

    // Round-robin: with both requesting, favour the one not granted last.
    always_comb begin
        grant_c = 2'b00;
        unique case (req_valid)
            2'b01:   grant_c = 2'b01;
            2'b10:   grant_c = 2'b10;
            2'b11:   grant_c = last_grant_q ? 2'b01 : 2'b10;
            default: grant_c = 2'b00;
        endcase
    end

    assign req_ready = (rst_n && state_q != S_COMMIT) ? grant_c : 2'b00;
    assign xfer_c    = |(req_valid & req_ready);
    assign sel_c     = req_ready[1];
    assign sel_x_c   = sel_c ? req_x[21:11]   : req_x[10:0];
    assign sel_y_c   = sel_c ? req_y[21:11]   : req_y[10:0];
    assign sel_rgb_c = sel_c ? req_rgb[23:12] : req_rgb[11:0];

    // Next state: capture into shadow, commit to active config on the vblank edge.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        shadow_x_d   = shadow_x_q;
        shadow_y_d   = shadow_y_q;
        shadow_rgb_d = shadow_rgb_q;
        rect_x_d     = rect_x_q;
        rect_y_d     = rect_y_q;
        rect_rgb_d   = rect_rgb_q;
        rect_en_d    = rect_en_q;
        commit_d     = 1'b0;
        frame_d      = frame_q + 16'(vblnk_rise_c);
`ifdef DRAW_RECT_CTL_STATS_EN
        drop_d       = drop_q;
        if (xfer_c && state_q == S_PENDING && drop_q != 8'hff) begin
            drop_d = drop_q + 8'd1;
        end
`endif
        if (xfer_c) begin
            shadow_x_d   = (sel_x_c > X_MAX) ? X_MAX : sel_x_c;
            shadow_y_d   = (sel_y_c > Y_MAX) ? Y_MAX : sel_y_c;
            shadow_rgb_d = sel_rgb_c;
            last_grant_d = sel_c;
        end

        unique case (state_q)
            S_IDLE: begin
                if (xfer_c) state_d = S_PENDING;
            end
            S_PENDING: begin
                if (vblnk_rise_c) begin
                    state_d    = S_COMMIT;
                    rect_x_d   = shadow_x_d;
                    rect_y_d   = shadow_y_d;
                    rect_rgb_d = shadow_rgb_d;
                    rect_en_d  = 1'b1;
                    commit_d   = 1'b1;
                end
            end
            S_COMMIT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            vblnk_d_q    <= 1'b0;
            last_grant_q <= 1'b1;
            shadow_x_q   <= '0;
            shadow_y_q   <= '0;
            shadow_rgb_q <= '0;
            rect_x_q     <= CW'(INIT_X);
            rect_y_q     <= CW'(INIT_Y);
            rect_rgb_q   <= INIT_RGB;
            rect_en_q    <= 1'b0;
            commit_q     <= 1'b0;
            frame_q      <= '0;
`ifdef DRAW_RECT_CTL_STATS_EN
            drop_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            vblnk_d_q    <= vblnk_in;
            last_grant_q <= last_grant_d;
            shadow_x_q   <= shadow_x_d;
            shadow_y_q   <= shadow_y_d;
            shadow_rgb_q <= shadow_rgb_d;
            rect_x_q     <= rect_x_d;
            rect_y_q     <= rect_y_d;
            rect_rgb_q   <= rect_rgb_d;
            rect_en_q    <= rect_en_d;
            commit_q     <= commit_d;
            frame_q      <= frame_d;
`ifdef DRAW_RECT_CTL_STATS_EN
            drop_q       <= drop_d;
`endif
        end
    end

    assign rect_x       = rect_x_q;
    assign rect_y       = rect_y_q;
    assign rect_rgb     = rect_rgb_q;
    assign rect_en      = rect_en_q;
    assign commit_pulse = commit_q;
    assign frame_cnt    = frame_q;
`ifdef DRAW_RECT_CTL_STATS_EN
    assign drop_cnt     = drop_q;
`endif

endmodule

// File: tb/tb_draw_rect_ctl.sv
// Directed + random bench for draw_rect_ctl against a transaction-level model of the
// pending-update / commit-at-vblank behaviour.
module tb_draw_rect_ctl;

    logic        pclk;
    logic        rst_n;
    logic        vblnk_in;
    logic [1:0]  req_valid;
    logic [21:0] req_x;
    logic [21:0] req_y;
    logic [23:0] req_rgb;
    logic [1:0]  req_ready;
    logic [10:0] rect_x;
    logic [10:0] rect_y;
    logic [11:0] rect_rgb;
    logic        rect_en;
    logic        commit_pulse;
    logic [15:0] frame_cnt;
`ifdef DRAW_RECT_CTL_STATS_EN
    logic [7:0]  drop_cnt;
`endif

    draw_rect_ctl dut (
        .pclk         (pclk),
        .rst_n        (rst_n),
        .vblnk_in     (vblnk_in),
        .req_valid    (req_valid),
        .req_x        (req_x),
        .req_y        (req_y),
        .req_rgb      (req_rgb),
        .req_ready    (req_ready),
        .rect_x       (rect_x),
        .rect_y       (rect_y),
        .rect_rgb     (rect_rgb),
        .rect_en      (rect_en),
        .commit_pulse (commit_pulse),
`ifdef DRAW_RECT_CTL_STATS_EN
        .drop_cnt     (drop_cnt),
`endif
        .frame_cnt    (frame_cnt)
    );

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    int errors = 0;
    int checks = 0;

    // Reference model: active config, outstanding update, frame/drop counts.
    logic [10:0] m_x, m_y, m_sx, m_sy;
    logic [11:0] m_rgb, m_srgb;
    logic        m_en, m_pulse, m_pending, m_commit_cyc, m_vprev;
    logic [15:0] m_frame;
    int          m_last;
    int          m_drop;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] clampv(input logic [10:0] v, input int unsigned lim);
        return (32'(v) > lim) ? 11'(lim) : v;
    endfunction

    task automatic model_reset();
        m_x = 11'd60; m_y = 11'd150; m_rgb = 12'hdf3;
        m_en = 1'b0; m_pulse = 1'b0; m_frame = 16'd0;
        m_pending = 1'b0; m_commit_cyc = 1'b0; m_vprev = 1'b0;
        m_sx = '0; m_sy = '0; m_srgb = '0;
        m_last = 1; m_drop = 0;
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, "_rect_x"},   32'(rect_x),       32'(m_x));
        chk({tag, "_rect_y"},   32'(rect_y),       32'(m_y));
        chk({tag, "_rect_rgb"}, 32'(rect_rgb),     32'(m_rgb));
        chk({tag, "_rect_en"},  32'(rect_en),      32'(m_en));
        chk({tag, "_commit"},   32'(commit_pulse), 32'(m_pulse));
        chk({tag, "_frame"},    32'(frame_cnt),    32'(m_frame));
`ifdef DRAW_RECT_CTL_STATS_EN
        chk({tag, "_drop"},     32'(drop_cnt),     32'(m_drop));
`endif
    endtask

    // One clock cycle; entered and left just after a falling edge.
    task automatic step(input logic [1:0] v, input logic [10:0] x0, input logic [10:0] x1,
                        input logic [10:0] y0, input logic [10:0] y1,
                        input logic [11:0] c0, input logic [11:0] c1, input logic vb);
        logic [1:0] exp_rdy;
        logic       rise, was_p;
        req_valid = v;
        req_x     = {x1, x0};
        req_y     = {y1, y0};
        req_rgb   = {c1, c0};
        vblnk_in  = vb;
        #1;
        if (m_commit_cyc)  exp_rdy = 2'b00;
        else if (v == 2'b11) exp_rdy = (m_last == 1) ? 2'b01 : 2'b10;
        else               exp_rdy = v;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        @(posedge pclk);
        rise    = vb & ~m_vprev;
        was_p   = m_pending;
        m_pulse = 1'b0;
        if (m_commit_cyc) begin
            m_commit_cyc = 1'b0;
        end else begin
            if ((v & exp_rdy) != 2'b00) begin
                m_last    = exp_rdy[1] ? 1 : 0;
                m_sx      = clampv(exp_rdy[1] ? x1 : x0, 770);
                m_sy      = clampv(exp_rdy[1] ? y1 : y0, 250);
                m_srgb    = exp_rdy[1] ? c1 : c0;
                m_pending = 1'b1;
                if (was_p && m_drop < 255) m_drop++;
            end
            if (was_p && rise) begin
                m_x = m_sx; m_y = m_sy; m_rgb = m_srgb;
                m_en = 1'b1; m_pulse = 1'b1;
                m_pending = 1'b0; m_commit_cyc = 1'b1;
            end
        end
        if (rise) m_frame = m_frame + 16'd1;
        m_vprev = vb;
        #1;
        chk_outputs("cyc");
        @(negedge pclk);
    endtask

    task automatic idle(input int n, input logic vb);
        for (int i = 0; i < n; i++) step(2'b00, '0, '0, '0, '0, '0, '0, vb);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = 2'b11;
        vblnk_in  = 1'b0;
        #1;
        model_reset();
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk_outputs("rst");
        @(negedge pclk);
        @(negedge pclk);
        chk("rst_ready_hold", 32'(req_ready), 32'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        logic        vb;
        logic [10:0] rx0, rx1, ry0, ry1;
        rst_n = 1'b0; vblnk_in = 1'b0; req_valid = '0;
        req_x = '0; req_y = '0; req_rgb = '0;
        model_reset();
        @(negedge pclk);
        do_reset();

        // Three frames with no requests: no commit, frame count advances.
        idle(3, 1'b0);
        for (int f = 0; f < 3; f++) begin
            idle(2, 1'b1);
            idle(3, 1'b0);
        end
        chk("t1_frame", 32'(frame_cnt), 32'd3);
        chk("t1_en", 32'(rect_en), 32'd0);

        // Single update held off until the vblank edge.
        step(2'b01, 11'd100, '0, 11'd200, '0, 12'hf00, '0, 1'b0);
        idle(3, 1'b0);
        chk("t2_hold_x", 32'(rect_x), 32'd60);
        idle(1, 1'b1);
        chk("t2_x", 32'(rect_x), 32'd100);
        chk("t2_y", 32'(rect_y), 32'd200);
        chk("t2_rgb", 32'(rect_rgb), 32'hf00);
        chk("t2_pulse", 32'(commit_pulse), 32'd1);
        idle(1, 1'b1);
        chk("t2_pulse_off", 32'(commit_pulse), 32'd0);
        idle(2, 1'b0);

        // Both requesters: grant 1 then 0, latest wins.
        step(2'b11, 11'd10, 11'd20, 11'd5, 11'd6, 12'h111, 12'h222, 1'b0);
        step(2'b11, 11'd10, 11'd20, 11'd5, 11'd6, 12'h111, 12'h222, 1'b0);
        idle(1, 1'b1);
        chk("t3_x", 32'(rect_x), 32'd10);
`ifdef DRAW_RECT_CTL_STATS_EN
        chk("t3_drop", 32'(drop_cnt), 32'd1);
`endif
        idle(2, 1'b0);

        // Clamp to the last legal position.
        step(2'b01, 11'd790, '0, 11'd590, '0, 12'h0f0, '0, 1'b0);
        idle(1, 1'b1);
        chk("t4_x", 32'(rect_x), 32'd770);
        chk("t4_y", 32'(rect_y), 32'd250);
        idle(2, 1'b0);

        // Accept on the vblank edge while pending: new value commits, ready drops.
        step(2'b10, '0, 11'd300, '0, 11'd100, '0, 12'h0ab, 1'b0);
        step(2'b01, 11'd400, '0, 11'd120, '0, 12'h123, '0, 1'b1);
        chk("t5_x", 32'(rect_x), 32'd400);
        chk("t5_y", 32'(rect_y), 32'd120);
        chk("t5_rgb", 32'(rect_rgb), 32'h123);
        step(2'b11, 11'd1, 11'd2, 11'd3, 11'd4, 12'h5, 12'h6, 1'b1);
        idle(2, 1'b0);

        // Reset while pending discards the update.
        step(2'b01, 11'd500, '0, 11'd50, '0, 12'h777, '0, 1'b0);
        do_reset();
        idle(2, 1'b0);
        idle(2, 1'b1);
        chk("t6_x", 32'(rect_x), 32'd60);
        chk("t6_en", 32'(rect_en), 32'd0);
        chk("t6_frame", 32'(frame_cnt), 32'd1);
        idle(2, 1'b0);

        // Random traffic.
        vb = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) vb = ~vb;
            rx0 = 11'($urandom_range(0, 2047));
            rx1 = 11'($urandom_range(0, 2047));
            ry0 = 11'($urandom_range(0, 2047));
            ry1 = 11'($urandom_range(0, 2047));
            step(($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b00,
                 rx0, rx1, ry0, ry1,
                 12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)), vb);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/draw_rect_ctl.md
Name: draw_rect_ctl

Overview:
Frame-synchronous controller for the rectangle-drawing stage of the VGA pipeline (800x600 active area, 12-bit RGB). It arbitrates position/colour update requests from two requesters (for example mouse logic and game logic) into a shadow register. It commits the shadow to the active rectangle configuration only at the start of vertical blanking, so the drawing stage never tears mid-frame.

Parameters:
H_ACTIVE, 800, active pixels per line
V_ACTIVE, 600, active lines per frame
RECT_W, 30, rectangle width in pixels
RECT_H, 350, rectangle height in lines
INIT_X, 60, rect_x after reset
INIT_Y, 150, rect_y after reset
INIT_RGB, 12'hdf3, rect_rgb after reset

Ports:
pclk  input  1  pixel clock; all logic on rising edge
rst_n  input  1  asynchronous, active-low reset
vblnk_in  input  1  vertical blank from timing generator
req_valid  input  2  per-requester update request; bit i = requester i
req_x  input  22  {x1[10:0], x0[10:0]} requested left edge
req_y  input  22  {y1[10:0], y0[10:0]} requested top edge
req_rgb  input  24  {rgb1, rgb0} requested colour
req_ready  output  2  per-requester accept; transfer when valid & ready
rect_x  output  11  active left edge for draw stage
rect_y  output  11  active top edge
rect_rgb  output  12  active colour
rect_en  output  1  draw stage enables rectangle when high
commit_pulse  output  1  one-cycle pulse when active config updates
frame_cnt  output  16  count of vblank rising edges

Behaviour:
- vblnk_in is registered into vblnk_d. vblnk_rise = vblnk_in & ~vblnk_d.
- FSM states: IDLE (no pending update), PENDING (shadow valid), COMMIT (one cycle).
- IDLE: an accepted request goes to PENDING. vblnk_rise stays in IDLE with no commit.
- PENDING: an accepted request overwrites the shadow (latest wins). vblnk_rise goes to COMMIT.
- COMMIT: copies shadow to rect_x/y/rgb, sets rect_en=1, asserts commit_pulse, then goes to IDLE.
- Arbitration: grant is combinational from req_valid, last_grant and state.
  - One valid bit: that requester is granted.
  - Both valid: the requester != last_grant is granted (round-robin).
  - last_grant updates on every transfer.
- req_ready[i] = grant[i] and state != COMMIT. The non-granted requester holds its valid.
- req_ready is 0 while rst_n is low.
- Simultaneous vblnk_rise and accepted request in PENDING: the shadow takes the new request and that value is committed.
- Simultaneous vblnk_rise and accepted request in IDLE: the request is captured and goes to PENDING. It commits on the next frame.
- Clamp at capture:
  - x > H_ACTIVE-RECT_W stores H_ACTIVE-RECT_W.
  - y > V_ACTIVE-RECT_H stores V_ACTIVE-RECT_H.
  - All arithmetic is 11-bit unsigned, with the clamp constants computed at elaboration.
- frame_cnt increments on every vblnk_rise in any state and wraps 16'hffff->0.
- Outputs are registered. Latency from vblnk_rise to new rect_x is 1 cycle (the COMMIT cycle). commit_pulse is high in the same cycle rect_x changes.
- Reset values: rect_x=INIT_X, rect_y=INIT_Y, rect_rgb=INIT_RGB, rect_en=0, commit_pulse=0, frame_cnt=0, state=IDLE, last_grant=1, vblnk_d=0, shadow=0.
- Reset mid-operation discards the pending shadow. The active config returns to the INIT_* values.

Optional Feature:
- Macro: DRAW_RECT_CTL_STATS_EN.
- Defined: adds output drop_cnt (8 bits, reset 0). It increments (saturating at 255) on each accepted request made while in PENDING, i.e. each overwritten, never-displayed update.
- Undefined: the drop_cnt port and its logic are absent. All other behaviour is identical.

Test Plan:
1. Reset release with no requests, 3 vblank rises -> rect_x=60, rect_y=150, rect_rgb=hdf3, rect_en=0, commit_pulse never high, frame_cnt=3.
2. Requester 0 sends x=100, y=200, rgb=f00 mid-frame -> outputs unchanged until vblnk_rise. One cycle after vblnk_rise: rect_x=100, rect_y=200, rect_rgb=f00, rect_en=1, one commit_pulse.
3. Both requesters valid for 2 cycles (x0=10, x1=20) -> grants alternate 1 then 0. rect_x=10 after the next vblank. With STATS_EN, drop_cnt=1.
4. Request x=790, y=590 -> committed rect_x=770, rect_y=250.
5. Request accepted in the same cycle as vblnk_rise while in PENDING -> the new value commits. req_ready=00 during the COMMIT cycle.
6. Assert rst_n low while in PENDING, then release -> no commit at the next vblank. Outputs hold the INIT_* values and frame_cnt restarts from 0.
